// File: rtl/poly_note_player_pkg.sv
// Shared types, fixed-point split and ROM contents for the polyphonic note player.
// The ROM tables are generated by functions so both ROMs stay single-source.
package poly_note_player_pkg;

    localparam int FREQ_ROM_LAT = 1;
    localparam int SINE_ROM_LAT = 1;
    localparam int FRAC_W       = 10;
    localparam int SINE_HALF    = 512;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } sweep_state_e;

    // Phase step for a note: the note index in the integer part,
    // i.e. the sine address advances by `note` entries per sample.
    function automatic int freq_lut(int note);
        return note << FRAC_W;
    endfunction

    // 10-bit sine table: parabolic half-wave, negated in the upper half.
    // Peak is 32640 so the value always fits a signed 16-bit sample.
    function automatic int sine_lut(int addr);
        int x;
        int v;
        x = addr & (SINE_HALF - 1);
        v = (x * (SINE_HALF - 1 - x)) >>> 1;
        if ((addr & SINE_HALF) != 0) v = -v;
        return v;
    endfunction

endpackage

// File: rtl/poly_note_player_if.sv
// Control/sample bus of the polyphonic note player.
// master: song reader/allocator + codec side; slave: the player.
interface poly_note_player_if #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int SAMPLE_W   = 16
);
    localparam int VW = $clog2(NUM_VOICES);

    logic                  play_enable;
    logic                  load_new_note;
    logic [VW-1:0]         voice_sel;
    logic [NOTE_W-1:0]     note_to_load;
    logic [DUR_W-1:0]      duration_to_load;
    logic                  beat;
    logic                  generate_next_sample;
    logic [NUM_VOICES-1:0] done_with_note;
    logic                  all_done;
    logic                  busy;
    logic                  overrun;
    logic [SAMPLE_W-1:0]   sample_out;
    logic                  new_sample_ready;

    modport master (
        output play_enable, load_new_note, voice_sel, note_to_load,
        output duration_to_load, beat, generate_next_sample,
        input  done_with_note, all_done, busy, overrun,
        input  sample_out, new_sample_ready
    );

    modport slave (
        input  play_enable, load_new_note, voice_sel, note_to_load,
        input  duration_to_load, beat, generate_next_sample,
        output done_with_note, all_done, busy, overrun,
        output sample_out, new_sample_ready
    );

endinterface

// File: rtl/poly_note_player_voice_slot.sv
// One voice: note register, beat-counted duration, phase accumulator.
// Ports: load/note_in/dur_in, beat, advance/step in; note, phase, done out.
module voice_slot #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int STEP_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [NOTE_W-1:0] note_in,
    input  logic [DUR_W-1:0]  dur_in,
    input  logic              beat,
    input  logic              advance,
    input  logic [STEP_W-1:0] step,
    output logic [NOTE_W-1:0] note,
    output logic [STEP_W-1:0] phase,
    output logic              done
);

    logic [DUR_W-1:0] remaining;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            note      <= '0;
            remaining <= '0;
            phase     <= '0;
        end else begin
            // A load wins over a same-cycle beat; phase is kept so reloads are click-free.
            if (load) begin
                note      <= note_in;
                remaining <= dur_in;
            end else if (beat && remaining != '0) begin
                remaining <= remaining - 1'b1;
            end
            if (advance) phase <= phase + step;
        end
    end

    assign done = (remaining == '0);

endmodule

// File: rtl/poly_note_player.sv
// Polyphonic note player: NUM_VOICES voices time-multiplexed over shared ROMs, mixed per request.
// Ports: clk, reset (async active-low), bus (slave modport: loads, beat, requests, sample out).
module poly_note_player
    import poly_note_player_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int STEP_W     = 20,
    parameter int SINE_AW    = 10,
    parameter int SAMPLE_W   = 16
) (
    input  logic clk,
    input  logic reset,
    poly_note_player_if.slave bus
);

    localparam int VW    = $clog2(NUM_VOICES);
    localparam int ACC_W = SAMPLE_W + VW;

    sweep_state_e state, state_nx;
    logic [VW-1:0] cnt, cnt_nx;
    logic issue, start, beat_en, last;

    logic [NOTE_W-1:0]     note_v  [NUM_VOICES];
    logic [STEP_W-1:0]     phase_v [NUM_VOICES];
    logic [NUM_VOICES-1:0] done_v;

    logic                       c1_vld, c2_vld;
    logic [VW-1:0]              c1_idx, c2_idx;
    logic [STEP_W-1:0]          step_q, phase_sum;
    logic [SINE_AW-1:0]         sine_addr;
    logic signed [SAMPLE_W-1:0] sine_q;
    logic signed [ACC_W-1:0]    acc, term, acc_sum, mix;
    logic [SAMPLE_W-1:0]        sample_q;
    logic                       ready_q, overrun_q;

    assign start   = bus.generate_next_sample && bus.play_enable && state == S_IDLE;
    assign beat_en = bus.beat && bus.play_enable;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        voice_slot #(
            .NOTE_W (NOTE_W),
            .DUR_W  (DUR_W),
            .STEP_W (STEP_W)
        ) u_slot (
            .clk     (clk),
            .reset   (reset),
            .load    (bus.load_new_note && bus.voice_sel == VW'(v)),
            .note_in (bus.note_to_load),
            .dur_in  (bus.duration_to_load),
            .beat    (beat_en),
            .advance (c1_vld && c1_idx == VW'(v)),
            .step    (step_q),
            .note    (note_v[v]),
            .phase   (phase_v[v]),
            .done    (done_v[v])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        issue    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_ISSUE;
                    cnt_nx   = '0;
                end
            end
            S_ISSUE: begin
                issue  = 1'b1;
                cnt_nx = cnt + 1'b1;
                if (cnt == VW'(NUM_VOICES - 1)) begin
                    state_nx = S_DRAIN;
                    cnt_nx   = '0;
                end
            end
            S_DRAIN: begin
                // Two cycles for the freq and sine ROM stages of the last voice.
                cnt_nx = cnt + 1'b1;
                if (cnt == VW'(1)) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // C1: new phase of the voice whose step just left the frequency ROM.
    assign phase_sum = phase_v[c1_idx] + step_q;
    assign sine_addr = phase_sum[STEP_W-1 -: SINE_AW];

    // C2: silence is decided on the duration as it stands now.
    assign term    = done_v[c2_idx] ? '0 : {{VW{sine_q[SAMPLE_W-1]}}, sine_q};
    assign acc_sum = acc + term;
    assign mix     = acc_sum >>> VW;
    assign last    = c2_vld && c2_idx == VW'(NUM_VOICES - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c1_vld    <= 1'b0;
            c2_vld    <= 1'b0;
            c1_idx    <= '0;
            c2_idx    <= '0;
            step_q    <= '0;
            sine_q    <= '0;
            acc       <= '0;
            sample_q  <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            c1_vld  <= issue;
            c1_idx  <= cnt;
            c2_vld  <= c1_vld;
            c2_idx  <= c1_idx;
            ready_q <= last;
            if (issue)  step_q <= STEP_W'(freq_lut(int'(note_v[cnt])));
            if (c1_vld) sine_q <= SAMPLE_W'(sine_lut(int'(sine_addr)));
            if (start)       acc <= '0;
            else if (c2_vld) acc <= acc_sum;
            if (last) sample_q <= mix[SAMPLE_W-1:0];
            if (bus.generate_next_sample && bus.play_enable && state != S_IDLE)
                overrun_q <= 1'b1;
        end
    end

    assign bus.done_with_note   = done_v;
    assign bus.all_done         = &done_v;
    assign bus.busy             = (state != S_IDLE);
    assign bus.overrun          = overrun_q;
    assign bus.sample_out       = sample_q;
    assign bus.new_sample_ready = ready_q;

endmodule

// File: tb/tb_poly_note_player.sv
// Directed bench for poly_note_player: vector table of load/beat/sweep steps
// plus hand-written sequences for overrun, load+beat, play_enable and reset corners.
module tb_poly_note_player;

    localparam int NV = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    poly_note_player_if #(.NUM_VOICES(NV)) bus ();

    poly_note_player #(.NUM_VOICES(NV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit ld;
        int vsel;
        int note;
        int dur;
        int nbeat;
        int nsweep;
        int exp_s;
        int exp_done;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic int smp();
        return int'($signed(bus.sample_out));
    endfunction

    task automatic load(int v, int note, int dur);
        @(negedge clk);
        bus.load_new_note    = 1'b1;
        bus.voice_sel        = 2'(v);
        bus.note_to_load     = 6'(note);
        bus.duration_to_load = 6'(dur);
        @(negedge clk);
        bus.load_new_note = 1'b0;
    endtask

    task automatic beats(int n);
        repeat (n) begin
            @(negedge clk);
            bus.beat = 1'b1;
            @(negedge clk);
            bus.beat = 1'b0;
        end
    endtask

    task automatic sweep(output int s);
        int  n;
        bit  seen;
        @(negedge clk);
        bus.generate_next_sample = 1'b1;
        @(posedge clk);
        #1;
        bus.generate_next_sample = 1'b0;
        chk("busy_after_accept", int'(bus.busy), 1);
        n    = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.new_sample_ready) seen = 1;
        end
        chk("ready_latency_edges", n, NV + 2);
        chk("busy_clear_at_ready", int'(bus.busy), 0);
        s = smp();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int s;
        int n_rdy;
        int act;
        reset                    = 1'b0;
        bus.play_enable          = 1'b1;
        bus.load_new_note        = 1'b0;
        bus.voice_sel            = '0;
        bus.note_to_load         = '0;
        bus.duration_to_load     = '0;
        bus.beat                 = 1'b0;
        bus.generate_next_sample = 1'b0;

        // Sine values: s(20)=4910 s(40)=9420 s(60)=13530 s(63)=14112
        // s(80)=17240 s(100)=20550 s(120)=23460 s(561)=-11319
        tbl[0] = '{1, 2, 20, 3, 0, 1, 1227, 4'b1011};
        tbl[1] = '{0, 0, 0, 0, 1, 1, 2355, 4'b1011};
        tbl[2] = '{0, 0, 0, 0, 2, 1, 0, 4'b1111};
        tbl[3] = '{1, 2, 20, 5, 0, 1, 4310, 4'b1011};
        tbl[4] = '{1, 0, 63, 2, 0, 1, 8665, 4'b1010};
        tbl[5] = '{0, 0, 0, 0, 2, 1, 5865, 4'b1011};
        tbl[6] = '{1, 2, 63, 20, 0, 7, -2830, 4'b1011};

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_sample", smp(), 0);
        chk("rst_done", int'(bus.done_with_note), 4'b1111);
        chk("rst_all_done", int'(bus.all_done), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_overrun", int'(bus.overrun), 0);
        chk("rst_ready", int'(bus.new_sample_ready), 0);

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].ld) load(tbl[i].vsel, tbl[i].note, tbl[i].dur);
            beats(tbl[i].nbeat);
            for (int k = 0; k < tbl[i].nsweep; k++) sweep(s);
            chk($sformatf("vec%0d_sample", i), s, tbl[i].exp_s);
            chk($sformatf("vec%0d_done", i), int'(bus.done_with_note), tbl[i].exp_done);
        end

        // All four voices on one note from phase 0: mix equals one voice.
        do_reset();
        for (int v = 0; v < NV; v++) load(v, 20, 10);
        chk("all_on_all_done", int'(bus.all_done), 0);
        sweep(s);
        chk("unison_sample", s, 4910);

        // Second request while busy is dropped and flags overrun.
        @(negedge clk);
        bus.generate_next_sample = 1'b1;
        repeat (2) @(negedge clk);
        bus.generate_next_sample = 1'b0;
        n_rdy = 0;
        repeat (14) begin
            @(posedge clk);
            #1;
            if (bus.new_sample_ready) begin
                n_rdy++;
                s = smp();
            end
        end
        chk("overrun_ready_pulses", n_rdy, 1);
        chk("overrun_sample", s, 9420);
        chk("overrun_set", int'(bus.overrun), 1);
        sweep(s);
        chk("overrun_next_sample", s, 13530);
        chk("overrun_sticky", int'(bus.overrun), 1);

        // Load and beat in one cycle: loaded voice takes new duration.
        load(0, 20, 5);
        @(negedge clk);
        bus.load_new_note    = 1'b1;
        bus.voice_sel        = 2'd1;
        bus.duration_to_load = 6'd7;
        bus.beat             = 1'b1;
        @(negedge clk);
        bus.load_new_note = 1'b0;
        bus.beat          = 1'b0;
        beats(3);
        chk("ldbeat_v0_at1", int'(bus.done_with_note), 4'b0000);
        beats(1);
        chk("ldbeat_v0_done", int'(bus.done_with_note), 4'b0001);
        load(1, 20, 0);
        chk("dur0_done", int'(bus.done_with_note), 4'b0011);

        // play_enable dropped mid-sweep: sweep completes, then inputs ignored.
        do_reset();
        chk("reset_clears_overrun", int'(bus.overrun), 0);
        load(3, 20, 2);
        @(negedge clk);
        bus.generate_next_sample = 1'b1;
        @(posedge clk);
        #1;
        bus.generate_next_sample = 1'b0;
        @(negedge clk);
        bus.play_enable = 1'b0;
        act = 0;
        for (int n = 0; n < 20 && act == 0; n++) begin
            @(posedge clk);
            #1;
            if (bus.new_sample_ready) act = 1;
        end
        chk("pe_off_sweep_finishes", act, 1);
        chk("pe_off_sample", smp(), 1227);
        beats(2);
        chk("pe_off_beats_ignored", int'(bus.done_with_note), 4'b0111);
        @(negedge clk);
        bus.generate_next_sample = 1'b1;
        @(negedge clk);
        bus.generate_next_sample = 1'b0;
        act = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.busy || bus.new_sample_ready) act = 1;
        end
        chk("pe_off_req_ignored", act, 0);
        chk("pe_off_no_overrun", int'(bus.overrun), 0);
        chk("pe_off_sample_held", smp(), 1227);

        // Asynchronous reset mid-sweep.
        @(negedge clk);
        bus.play_enable          = 1'b1;
        bus.generate_next_sample = 1'b1;
        @(posedge clk);
        #1;
        bus.generate_next_sample = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("midreset_busy", int'(bus.busy), 0);
        chk("midreset_sample", smp(), 0);
        chk("midreset_done", int'(bus.done_with_note), 4'b1111);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.new_sample_ready) act = 1;
        end
        chk("midreset_no_ready", act, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
